// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 8-digit multiplexed seven-segment driver with tear-free double-buffered updates
module seven_seg_scanner #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 4,
  parameter int BLANK_LEADING  = 1
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        data_valid,
  input  logic [7:0]  digit_en,
  output logic [7:0]  AN,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        frame_done,
  output logic        update_ack
);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BL   = CW'(BLANK_CYCLES);
  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [0:0]    r_state;
  logic [31:0]   r_pend;
  logic [7:0]    r_pend_dp;
  logic          r_pend_vld;
  logic [31:0]   r_sh;
  logic [7:0]    r_sh_dp;

  logic          w_wrap;
  logic          w_commit;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_nib;
  logic          w_lead;
  logic          w_on;
  logic [6:0]    w_seg;

  // slot timing, commit point and whether the current digit is actually lit
  always_comb begin
    w_wrap    = r_cnt == LAST;
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_commit  = w_wrap && r_idx == 3'd7;
    w_nib     = r_sh[{r_idx, 2'b00} +: 4];
    w_lead    = (BLANK_LEADING != 0) && r_idx != 3'd0 && (r_sh >> {r_idx, 2'b00}) == 32'd0;
    w_on      = r_state == S_DRIVE && digit_en[r_idx] && !w_lead;
  end

  // hex nibble to active-low {g,f,e,d,c,b,a}
  always_comb begin
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

  // slot counter, digit scan index and blank/drive phase (phase tracks the next count)
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_state <= S_BLANK;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_wrap ? r_idx + 3'd1 : r_idx;
      r_state <= (w_cnt_nxt >= BL) ? S_DRIVE : S_BLANK;
    end
  end

  // pending capture; shadow only reloads at the frame boundary, taking the pre-strobe pending value
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_pend     <= 32'd0;
      r_pend_dp  <= 8'd0;
      r_pend_vld <= 1'b0;
      r_sh       <= 32'd0;
      r_sh_dp    <= 8'd0;
    end else begin
      if (w_commit && r_pend_vld) begin
        r_sh       <= r_pend;
        r_sh_dp    <= r_pend_dp;
        r_pend_vld <= 1'b0;
      end
      if (data_valid) begin
        r_pend     <= data_in;
        r_pend_dp  <= dp_in;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // registered display outputs and boundary pulses
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN         <= 8'hFF;
      segment    <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      update_ack <= 1'b0;
    end else begin
      AN         <= w_on ? ~(8'd1 << r_idx) : 8'hFF;
      segment    <= w_on ? w_seg : 7'h7F;
      dp         <= w_on ? ~r_sh_dp[r_idx] : 1'b1;
      frame_done <= w_commit;
      update_ack <= w_commit && r_pend_vld;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized and directed check of the scanner against a frame-position model
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [7:0]  dp_in = 8'd0;
  logic        dv = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  an1, an2;
  logic [6:0]  seg1, seg2;
  logic        dp1, dp2, fd1, fd2, ack1, ack2;

  int n_chk = 0;
  int n_pass = 0;
  int n = 0;
  logic [31:0] m_sh = 32'd0, m_pend = 32'd0;
  logic [7:0]  m_sh_dp = 8'd0, m_pend_dp = 8'd0;
  bit          m_flag = 1'b0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scanner #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2), .BLANK_LEADING(1)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .data_in(data_in), .dp_in(dp_in), .data_valid(dv),
    .digit_en(digit_en), .AN(an1), .segment(seg1), .dp(dp1), .frame_done(fd1), .update_ack(ack1));

  seven_seg_scanner #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2), .BLANK_LEADING(0)) dut_nl (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .data_in(data_in), .dp_in(dp_in), .data_valid(dv),
    .digit_en(digit_en), .AN(an2), .segment(seg2), .dp(dp2), .frame_done(fd2), .update_ack(ack2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t (frame pos %0d)", tag, got, exp, $time, (n - 1) % 64);
  endtask

  // one clock: predict from frame position n, advance the model, then compare
  task automatic tick();
    int p, idx, hi;
    bit on1, on2;
    logic [7:0] one, e_an1, e_an2;
    logic [6:0] e_seg;
    logic e_dp, e_fd, e_ack;
    one = 8'h01;
    @(posedge clk);
    p = n % 64;
    idx = p / 8;
    hi = 0;
    for (int i = 0; i < 8; i++) if (m_sh[4*i +: 4] != 4'd0) hi = i;
    on2 = (p % 8 >= 2) && digit_en[idx];
    on1 = on2 && idx <= hi;
    e_an1 = on1 ? ~(one << idx) : 8'hFF;
    e_an2 = on2 ? ~(one << idx) : 8'hFF;
    e_seg = seg_tab[m_sh[4*idx +: 4]];
    e_dp = ~m_sh_dp[idx];
    e_fd = p == 63;
    e_ack = p == 63 && m_flag;
    if (p == 63 && m_flag) begin
      m_sh = m_pend;
      m_sh_dp = m_pend_dp;
      m_flag = 1'b0;
    end
    if (dv) begin
      m_pend = data_in;
      m_pend_dp = dp_in;
      m_flag = 1'b1;
    end
    n++;
    #1;
    chk("an", an1, e_an1);
    chk("an_nolead", an2, e_an2);
    if (on1) begin
      chk("seg", seg1, e_seg);
      chk("dp", dp1, e_dp);
    end
    if (on2) chk("seg_nolead", seg2, e_seg);
    chk("frame_done", fd1, e_fd);
    chk("update_ack", ack1, e_ack);
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic align(input int pos);
    while (n % 64 != pos) tick();
  endtask

  task automatic strobe(input logic [31:0] d, input logic [7:0] p);
    data_in = d;
    dp_in = p;
    dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, an1, 8'hFF);
    chk({tag, "_seg"}, seg1, 7'h7F);
    chk({tag, "_dp"}, dp1, 1'b1);
    chk({tag, "_fd"}, fd1, 1'b0);
    chk({tag, "_ack"}, ack1, 1'b0);
    chk({tag, "_an_nolead"}, an2, 8'hFF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    run(70);
    align(20);
    strobe(32'h89ABCDEF, 8'h01);
    run(128);
    strobe(32'h00000120, 8'h00);
    run(128);
    digit_en = 8'hFD;
    strobe(32'h11111111, 8'h00);
    run(128);
    digit_en = 8'hFF;
    align(10);
    strobe(32'h1, 8'h00);
    run(5);
    strobe(32'h2, 8'h00);
    run(128);
    align(63);
    strobe(32'h3, 8'h02);
    run(128);
    align(40);
    strobe(32'h4, 8'h00);
    align(63);
    strobe(32'h5, 8'h01);
    run(128);
    for (int k = 0; k < 500; k++) begin
      dv = $urandom_range(0, 19) == 0;
      data_in = $urandom >> (4 * $urandom_range(0, 8));
      dp_in = 8'($urandom);
      if ($urandom_range(0, 49) == 0) digit_en = 8'($urandom);
      tick();
    end
    dv = 1'b0;
    digit_en = 8'hFF;
    strobe(32'h00765432, 8'h20);
    run(64);
    align(44);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    n = 0;
    m_sh = 32'd0;
    m_pend = 32'd0;
    m_sh_dp = 8'd0;
    m_pend_dp = 8'd0;
    m_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("midrst_hold");
    rst_n = 1'b1;
    run(70);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit hex value produced by the clock-crossing counter logic and drives AN/segment directly. Display updates are double-buffered and committed only at frame boundaries to prevent tearing. A per-slot blanking interval suppresses ghosting.

Parameters:
REFRESH_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off; must be < REFRESH_CYCLES.
BLANK_LEADING, 1, 1 = suppress leading-zero digits 7..1.

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
data_in  in  32  hex value; nibble i is shown on digit i
dp_in  in  8  decimal-point enables, bit i = digit i, active-high
data_valid  in  1  capture strobe for data_in/dp_in
digit_en  in  8  per-digit enable, active-high; sampled live
AN  out  8  anode selects, active-low
segment  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal-point cathode, active-low
frame_done  out  1  1-cycle pulse at the digit 7 -> 0 wrap
update_ack  out  1  1-cycle pulse when the shadow register loads

Behaviour:
- Reset (async, CPU_RESETN=0): AN=8'hFF, segment=7'h7F, dp=1, frame_done=0, update_ack=0, slot counter cnt=0, digit_idx=0, state=BLANK, pending register=0, pending flag=0, shadow data=0, shadow dp=0.
- cnt counts 0..REFRESH_CYCLES-1 and then wraps to 0. On each wrap, digit_idx increments modulo 8.
- FSM state BLANK: active while cnt < BLANK_CYCLES. Transitions to DRIVE when cnt reaches BLANK_CYCLES.
- FSM state DRIVE: active for the rest of the slot. Transitions to BLANK on the cnt wrap.
- All outputs are registered. AN, segment and dp reflect the state/cnt/digit_idx of the previous cycle (1-cycle latency).
- In BLANK: AN=8'hFF, segment=7'h7F, dp=1.
- In DRIVE: AN has only bit digit_idx low, unless that digit is suppressed. A suppressed digit gives AN=8'hFF; its slot still consumes full time.
- Suppression conditions:
  - digit_en[digit_idx]=0, or
  - BLANK_LEADING=1 and digit_idx != 0 and shadow nibbles digit_idx..7 are all zero.
  - Digit 0 is never leading-blanked.
- dp = ~shadow_dp[digit_idx] whenever the digit is driven.
- Hex decode (segment value):
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Capture: data_valid=1 loads data_in/dp_in into the pending register and sets the pending flag. Multiple strobes within one frame overwrite; last value wins.
- Commit: on the cycle digit_idx wraps 7 -> 0:
  - frame_done=1.
  - If the pending flag is set: shadow <= pending register, pending flag cleared, update_ack=1 on the same cycle.
- Simultaneous data_valid and commit: the shadow receives the old pending content. The new data stays pending (flag remains set) and commits at the next frame boundary. If the pending flag was clear, no commit occurs, and the new data waits one full frame.
- digit_en changes take effect at the next registered output update, not at the frame boundary.
- Reset asserted mid-frame: all state returns to reset values immediately. Pending data is lost.

Test Plan:
Use REFRESH_CYCLES=8, BLANK_CYCLES=2 (frame = 64 cycles) for all scenarios.
1. Hold reset, then release with no data -> AN=FF for cycles 0-2. Then AN=FE with segment=40 (digit 0 shows "0"). Digits 1-7 are leading-blanked (AN=FF in their slots). frame_done pulses at cycle 64.
2. data_valid with data_in=32'h89ABCDEF, dp_in=8'h01 mid-frame -> update_ack and frame_done coincide at the next wrap. In the following frame:
   - digit 0: AN=FE, segment=0E, dp=0.
   - digit 7: AN=7F, segment=00, dp=1.
3. data_in=32'h00000120 committed -> digits 0/1/2 show 40/24/79. Digits 3-7 give AN=FF. With BLANK_LEADING=0, digits 3-7 show 40.
4. digit_en=8'hFD with data 32'h11111111 -> the digit 1 slot gives AN=FF. All other digits give segment=79.
5. Two strobes (32'h1, then 32'h2) within one frame -> a single update_ack; digit 0 shows 24. A strobe on the exact commit cycle -> no ack at that wrap when nothing was pending, then ack one frame later.
6. Assert CPU_RESETN=0 during DRIVE of digit 5 -> same cycle AN=FF, segment=7F, no pulses. After release, the scan restarts at digit 0 showing "0".
